// File: rtl/mult_sched_if.sv
// Handshake bundle for mult_sched: two operand requesters and one result consumer.
interface mult_sched_if;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned RES_W = 32;

  logic             req0_valid;
  logic [OP_W-1:0]  req0_a;
  logic [OP_W-1:0]  req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [OP_W-1:0]  req1_a;
  logic [OP_W-1:0]  req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_id;
  logic [RES_W-1:0] res_product;
  logic             res_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_id, res_product
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_id, res_product
  );
endinterface

// File: rtl/mult_sched.sv
// Two-requester 16x16 multiplier sharing one 16x4 multiplier over four nibble steps.
module mult16by4 (
  input  logic [15:0] a,
  input  logic [3:0]  b,
  output logic [19:0] product
);
  assign product = 20'(a) * 20'(b);
endmodule

module mult_sched (
  input  logic         clk,
  input  logic         rst,
  mult_sched_if.slave  bus
);
  localparam int unsigned OP_W   = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PROD_W = 20;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned K_W    = 2;
  localparam int unsigned STEPS  = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_d;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              id_q;
  logic [RES_W-1:0]  acc;
  logic [K_W-1:0]    k;
  logic              last_grant;
  logic              res_valid_q;
  logic              res_id_q;
  logic [RES_W-1:0]  res_product_q;

  logic              grant_c;
  logic              accept_c;
  logic              last_step_c;
  logic [NIB_W-1:0]  nib_c;
  logic [PROD_W-1:0] prod_c;
  logic [RES_W-1:0]  sum_c;

  // Round-robin: on a tie, the requester not served last wins.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_c = ~last_grant;
    else                                  grant_c = bus.req1_valid;
  end

  assign last_step_c = (k == K_W'(STEPS - 1));
  assign nib_c       = NIB_W'(b_q >> {k, 2'b00});
  assign sum_c       = acc + (RES_W'(prod_c) << {k, 2'b00});

  mult16by4 u_mult (
    .a       (a_q),
    .b       (nib_c),
    .product (prod_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d        = state;
    accept_c       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        accept_c       = !rst && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = accept_c && !grant_c;
        bus.req1_ready = accept_c && grant_c;
        if (accept_c) state_d = CALC;
      end
      CALC: if (last_step_c) state_d = DONE;
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, nibble accumulation and result holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      acc           <= '0;
      k             <= '0;
      last_grant    <= 1'b1;
      res_valid_q   <= 1'b0;
      res_id_q      <= 1'b0;
      res_product_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            a_q        <= grant_c ? bus.req1_a : bus.req0_a;
            b_q        <= grant_c ? bus.req1_b : bus.req0_b;
            id_q       <= grant_c;
            last_grant <= grant_c;
            acc        <= '0;
            k          <= '0;
          end
        end
        CALC: begin
          acc <= sum_c;
          k   <= k + K_W'(1);
          if (last_step_c) begin
            res_valid_q   <= 1'b1;
            res_id_q      <= id_q;
            res_product_q <= sum_c;
          end
        end
        DONE: if (bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_product = res_product_q;
endmodule
